// File: rtl/sd_pkg.sv
// Shared constants and width helpers for the sinc3 sigma-delta decimator.
package sd_pkg;

   localparam int PCM_W     = 32'sd16;
   localparam int CIC_ORDER = 32'sd3;

   typedef logic signed [PCM_W-1:0] pcm_t;

   // Bit growth of a sinc3 filter is 3*log2(DECIM); two extra bits hold the +/-1 input and its sign.
   function automatic int cic_width(input int decim);
      return 32'sd2 + CIC_ORDER * $clog2(decim);
   endfunction

   function automatic int out_shift(input int decim);
      return CIC_ORDER * $clog2(decim) - (PCM_W - 32'sd1);
   endfunction

endpackage

// File: rtl/sd_decimator_if.sv
// Bitstream input and PCM output bundle of the sinc3 decimator.
interface sd_decimator_if;
   import sd_pkg::*;

   logic sd_in;
   logic in_valid;
   pcm_t pcm_out;
   logic pcm_valid;

   modport master (output sd_in, output in_valid, input pcm_out, input pcm_valid);
   modport slave  (input sd_in, input in_valid, output pcm_out, output pcm_valid);

endinterface

// File: rtl/sd_cic_stage.sv
// One W-bit wrapping CIC integrator; accumulates in_i on cycles where en_i is high.
module sd_cic_stage #(
   parameter int W = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic signed [W-1:0] in_i,
   output logic signed [W-1:0] acc_o
);

   logic signed [W-1:0] acc_q;
   logic signed [W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (en_i) begin
         acc_d = acc_q + in_i;
      end else begin
         acc_d = acc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= {W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/sd_decimator.sv
// sinc3 CIC decimator: 1-bit sigma-delta stream in, saturated Q1.15 PCM out every DECIM accepted bits.
// Defining SD_DECIMATOR_OVF_FLAG_EN adds a sticky saturation flag on output port ovf.
module sd_decimator
   import sd_pkg::*;
#(
   parameter int DECIM = 64
) (
   input  logic          clk,
   input  logic          rst,
   sd_decimator_if.slave bus
`ifdef SD_DECIMATOR_OVF_FLAG_EN
   ,
   output logic          ovf
`endif
);

   localparam int W     = cic_width(DECIM);
   localparam int SHIFT = out_shift(DECIM);
   localparam int CNT_W = $clog2(DECIM);

   localparam logic [CNT_W-1:0]    CNT_LAST  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic signed [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
   localparam logic signed [W-1:0] PCM_MAX_W = {{(W-PCM_W+1){1'b0}}, {(PCM_W-1){1'b1}}};
   localparam logic signed [W-1:0] PCM_MIN_W = {{(W-PCM_W+1){1'b1}}, {(PCM_W-1){1'b0}}};
   localparam pcm_t                PCM_MAX   = {1'b0, {(PCM_W-1){1'b1}}};
   localparam pcm_t                PCM_MIN   = {1'b1, {(PCM_W-1){1'b0}}};

   logic signed [W-1:0] in_term_s;
   logic signed [W-1:0] int1_s;
   logic signed [W-1:0] int2_s;
   logic signed [W-1:0] int3_s;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                frame_done_q, frame_done_d;
   logic signed [W-1:0] dly1_q, dly1_d;
   logic signed [W-1:0] dly2_q, dly2_d;
   logic signed [W-1:0] dly3_q, dly3_d;
   logic signed [W-1:0] comb_q, comb_d;
   logic signed [W-1:0] c1_s, c2_s, c3_s;
   logic [1:0]          settle_q, settle_d;
   logic                strobe_pend_q, strobe_pend_d;
   logic signed [W-1:0] scaled_s;
   pcm_t                sat_s;
   pcm_t                pcm_out_q, pcm_out_d;
   logic                pcm_valid_q, pcm_valid_d;

   always_comb begin
      in_term_s = ONE_W;
      if (bus.sd_in) begin
         in_term_s = ONE_W;
      end else begin
         in_term_s = {W{1'b1}};
      end
   end

   sd_cic_stage #(.W(W)) u_int1 (
      .clk   (clk),
      .rst   (rst),
      .en_i  (bus.in_valid),
      .in_i  (in_term_s),
      .acc_o (int1_s)
   );

   sd_cic_stage #(.W(W)) u_int2 (
      .clk   (clk),
      .rst   (rst),
      .en_i  (bus.in_valid),
      .in_i  (int1_s),
      .acc_o (int2_s)
   );

   sd_cic_stage #(.W(W)) u_int3 (
      .clk   (clk),
      .rst   (rst),
      .en_i  (bus.in_valid),
      .in_i  (int2_s),
      .acc_o (int3_s)
   );

   always_comb begin
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (bus.in_valid) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d        = {CNT_W{1'b0}};
            frame_done_d = 1'b1;
         end else begin
            cnt_d        = cnt_q + CNT_ONE;
            frame_done_d = 1'b0;
         end
      end else begin
         cnt_d        = cnt_q;
         frame_done_d = 1'b0;
      end
   end

   // The last integrator still holds the frame's post-update value on the cycle after the final bit.
   always_comb begin
      c1_s          = int3_s - dly1_q;
      c2_s          = c1_s - dly2_q;
      c3_s          = c2_s - dly3_q;
      dly1_d        = dly1_q;
      dly2_d        = dly2_q;
      dly3_d        = dly3_q;
      comb_d        = comb_q;
      settle_d      = settle_q;
      strobe_pend_d = 1'b0;
      if (frame_done_q) begin
         dly1_d        = int3_s;
         dly2_d        = c1_s;
         dly3_d        = c2_s;
         comb_d        = c3_s;
         strobe_pend_d = (settle_q == 2'd3);
         if (settle_q != 2'd3) begin
            settle_d = settle_q + 2'd1;
         end else begin
            settle_d = settle_q;
         end
      end else begin
         strobe_pend_d = 1'b0;
      end
   end

   always_comb begin
      scaled_s = comb_q >>> SHIFT;
      sat_s    = scaled_s[PCM_W-1:0];
      if (scaled_s > PCM_MAX_W) begin
         sat_s = PCM_MAX;
      end else if (scaled_s < PCM_MIN_W) begin
         sat_s = PCM_MIN;
      end else begin
         sat_s = scaled_s[PCM_W-1:0];
      end
      pcm_valid_d = strobe_pend_q;
      pcm_out_d   = pcm_out_q;
      if (strobe_pend_q) begin
         pcm_out_d = sat_s;
      end else begin
         pcm_out_d = pcm_out_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= {CNT_W{1'b0}};
         frame_done_q  <= 1'b0;
         dly1_q        <= {W{1'b0}};
         dly2_q        <= {W{1'b0}};
         dly3_q        <= {W{1'b0}};
         comb_q        <= {W{1'b0}};
         settle_q      <= 2'd0;
         strobe_pend_q <= 1'b0;
         pcm_out_q     <= {PCM_W{1'b0}};
         pcm_valid_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         frame_done_q  <= frame_done_d;
         dly1_q        <= dly1_d;
         dly2_q        <= dly2_d;
         dly3_q        <= dly3_d;
         comb_q        <= comb_d;
         settle_q      <= settle_d;
         strobe_pend_q <= strobe_pend_d;
         pcm_out_q     <= pcm_out_d;
         pcm_valid_q   <= pcm_valid_d;
      end
   end

   assign bus.pcm_out   = pcm_out_q;
   assign bus.pcm_valid = pcm_valid_q;

`ifdef SD_DECIMATOR_OVF_FLAG_EN
   logic sat_hit_s;
   logic ovf_q, ovf_d;

   always_comb begin
      sat_hit_s = (scaled_s > PCM_MAX_W) || (scaled_s < PCM_MIN_W);
      ovf_d     = ovf_q;
      if (strobe_pend_q && sat_hit_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sd_decimator.sv
// Self-checking bench for sd_decimator (DECIM=64) against an unbounded-integer sinc3 reference model.
module tb_sd_decimator;
   import sd_pkg::*;

   localparam int DECIM = 64;
   localparam int SHIFT = 3;   // 3*log2(64) - 15

   logic clk;
   logic rst;
   sd_decimator_if bus ();
`ifdef SD_DECIMATOR_OVF_FLAG_EN
   logic ovf;
`endif

   sd_decimator #(.DECIM(DECIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SD_DECIMATOR_OVF_FLAG_EN
      ,
      .ovf (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk = 0;
   int errs = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int final_edges[$];
   int strobe_edges[$];
   int strobe_vals[$];
   int exp_vals[$];
   int ref_vals[$];
   bit sent_bits[$];
   bit exp_ovf;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change at posedge+1, so at the negedge in_valid belongs to the next edge and
   // pcm_valid to the previous one.
   always @(negedge clk) begin
      if (rst) begin
         acc_cnt = 0;
      end else begin
         if (bus.pcm_valid) begin
            strobe_edges.push_back(cyc);
            strobe_vals.push_back(int'(bus.pcm_out));
         end
         if (bus.in_valid) begin
            if (acc_cnt == DECIM - 1) begin
               final_edges.push_back(cyc + 1);
               acc_cnt = 0;
            end else begin
               acc_cnt++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      chk++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_bit(input bit b, input int gap);
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.sd_in    = b;
      bus.in_valid = 1'b1;
      sent_bits.push_back(b);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic clear_logs();
      sent_bits.delete();
      final_edges.delete();
      strobe_edges.delete();
      strobe_vals.delete();
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_pcm_out", bus.pcm_out, 0);
      check("rst_pcm_valid", bus.pcm_valid, 0);
`ifdef SD_DECIMATOR_OVF_FLAG_EN
      check("rst_ovf", ovf, 0);
`endif
      rst = 1'b0;
      clear_logs();
      tick();
   endtask

   // sinc3 over the accepted bits: triple running sums sampled every DECIM bits, then a third difference.
   function automatic void build_model();
      longint s1 = 0;
      longint s2 = 0;
      longint s3 = 0;
      longint v[$];
      longint c;
      longint sh;
      int n = 0;
      exp_vals.delete();
      exp_ovf = 1'b0;
      foreach (sent_bits[k]) begin
         s3 += s2;
         s2 += s1;
         s1 += sent_bits[k] ? 1 : -1;
         n++;
         if (n == DECIM) begin
            v.push_back(s3);
            n = 0;
         end
      end
      for (int f = 3; f < v.size(); f++) begin
         c  = v[f] - 3 * v[f-1] + 3 * v[f-2] - v[f-3];
         sh = c >>> SHIFT;
         if (sh > 32767) begin
            sh = 32767;
            exp_ovf = 1'b1;
         end else if (sh < -32768) begin
            sh = -32768;
            exp_ovf = 1'b1;
         end
         exp_vals.push_back(int'(sh));
      end
   endfunction

   task automatic check_run(input string tag);
      int exp_edge;
      build_model();
      check({tag, "_count"}, strobe_vals.size(), exp_vals.size());
      for (int i = 0; i < strobe_vals.size() && i < exp_vals.size(); i++) begin
         check({tag, "_value"}, strobe_vals[i], exp_vals[i]);
         exp_edge = (i + 3 < final_edges.size()) ? final_edges[i+3] + 2 : -1;
         check({tag, "_timing"}, strobe_edges[i], exp_edge);
      end
      if (exp_vals.size() > 0) check({tag, "_hold"}, bus.pcm_out, exp_vals[exp_vals.size()-1]);
`ifdef SD_DECIMATOR_OVF_FLAG_EN
      check({tag, "_ovf"}, ovf, exp_ovf);
`endif
   endtask

   initial begin
      longint u;
      longint x1;
      longint x2;
      longint y;
      bit dac_bits[$];

      rst = 1'b1;
      bus.sd_in = 1'b0;
      bus.in_valid = 1'b0;
      #2;
      check("por_pcm_out", bus.pcm_out, 0);
      check("por_pcm_valid", bus.pcm_valid, 0);
      tick();

      // All ones: saturates to +32767 from the 4th frame.
      do_reset();
      for (int k = 0; k < 6 * DECIM; k++) send_bit(1'b1, 0);
      idle(4);
      check_run("ones");
      check("ones_sat", bus.pcm_out, 32767);

      // All zeros: exactly -32768, no saturation.
      do_reset();
      for (int k = 0; k < 6 * DECIM; k++) send_bit(1'b0, 0);
      idle(4);
      check_run("zeros");
      check("zeros_min", bus.pcm_out, -32768);

      // Alternating 1,0 for 640 bits: 7 strobes, all zero.
      do_reset();
      for (int k = 0; k < 10 * DECIM; k++) send_bit((k % 2) == 0, 0);
      idle(4);
      check_run("alt");
      check("alt_pulses", strobe_vals.size(), 7);
      foreach (strobe_vals[i]) check("alt_zero", strobe_vals[i], 0);
      ref_vals = strobe_vals;

      // Same stream with random gaps must reproduce the gap-free output.
      do_reset();
      for (int k = 0; k < 10 * DECIM; k++) send_bit((k % 2) == 0, $urandom_range(0, 5));
      idle(4);
      check_run("alt_gap");
      check("alt_gap_count", strobe_vals.size(), ref_vals.size());
      for (int i = 0; i < strobe_vals.size() && i < ref_vals.size(); i++)
         check("alt_gap_same", strobe_vals[i], ref_vals[i]);

      // Random bits with random gaps.
      do_reset();
      for (int k = 0; k < 10 * DECIM; k++) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 5));
      idle(4);
      check_run("rand");

      // Reset at bit 30 of frame 5, then settling restarts.
      do_reset();
      for (int k = 0; k < 5 * DECIM + 30; k++) send_bit(1'b1, 0);
      check("pre_rst_out", bus.pcm_out, 32767);
      rst = 1'b1;
      #1;
      check("mid_rst_out", bus.pcm_out, 0);
      check("mid_rst_valid", bus.pcm_valid, 0);
      tick();
      rst = 1'b0;
      clear_logs();
      tick();
      for (int k = 0; k < 3 * DECIM; k++) send_bit(1'b1, 0);
      idle(4);
      check("resettle_none", strobe_vals.size(), 0);
      for (int k = 0; k < DECIM; k++) send_bit(1'b1, 0);
      idle(4);
      check_run("resettle");
      check("resettle_one", strobe_vals.size(), 1);

      // Reset right after a settled frame's final bit discards the pending strobe.
      clear_logs();
      for (int k = 0; k < DECIM; k++) send_bit(1'b1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_logs();
      idle(6);
      check("pending_drop", strobe_vals.size(), 0);

      // Loopback from a 2nd-order sigma-delta modulator at DC 0x4000.
      do_reset();
      u  = 16384;
      x1 = 0;
      x2 = 0;
      y  = 32768;
      for (int k = 0; k < 12 * DECIM; k++) begin
         y  = (x2 >= 0) ? 32768 : -32768;
         dac_bits.push_back(x2 >= 0);
         x1 = x1 + u - y;
         x2 = x2 + x1 - y;
      end
      foreach (dac_bits[k]) send_bit(dac_bits[k], 0);
      idle(4);
      check_run("dac");
      foreach (strobe_vals[i])
         check("dac_range", (strobe_vals[i] >= 16384 - 64 && strobe_vals[i] <= 16384 + 64) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", chk, errs);
      $finish;
   end

endmodule
